// File: rtl/serial_pkg.sv
// Shared definitions for the serial pattern transmitter and the benches that
// decode its state.
//   state_e   : FSM state encoding (2 bits)
//   PAT_W_DEF : default pattern width
//   CNT_W_DEF : default repeat-count width
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10,
    DONE  = 2'b11
  } state_e;

  localparam int unsigned PAT_W_DEF = 3;
  localparam int unsigned CNT_W_DEF = 4;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register, MSB first.
//   clk, reset : clock, asynchronous active-high reset
//   load       : capture din (has priority over shift)
//   shift      : shift left by one, zero enters at the LSB
//   din        : parallel load data
//   msb        : current MSB of the register
module piso_shift_reg #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] shift_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
    end else if (load) begin
      shift_q <= din;
    end else if (shift) begin
      shift_q <= shift_q << 1;
    end
  end

  assign msb = shift_q[WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: loads a pattern and repeat count over a
// valid/ready handshake, then shifts the pattern out MSB first, repeat_cnt+1
// times, followed by a one-cycle done pulse.
// Optional feature: define SERIAL_PATTERN_TX_GAP_EN to insert one idle cycle
// (GAP state) between consecutive repetitions.
//   clk, reset  : clock, asynchronous active-high reset
//   load_valid  : load request; load_ready high only in IDLE
//   pattern     : PAT_W-bit pattern, bit PAT_W-1 sent first
//   repeat_cnt  : extra repetitions after the first
//   abort       : synchronous abort while transmitting
//   ser_out     : serial bit (0 whenever ser_valid is low)
//   ser_valid   : ser_out carries a pattern bit
//   busy        : transmission in progress
//   done        : pulse after the last bit of the last repetition
module serial_pattern_tx
  import serial_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IdxW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IdxW-1:0] BitMax = IdxW'(PAT_W - 1);

  state_e            state_q, state_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [CNT_W-1:0]  rep_q, rep_d;
  logic [IdxW-1:0]   bit_q, bit_d;
  logic              ser_valid_q, ser_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sr_load, sr_shift;
  logic [PAT_W-1:0]  sr_din;

  // The shift register MSB is the registered serial output. It is zero
  // whenever no bit is being sent because every exit from a bit cycle either
  // shifts the last bit out (zeros fill in) or loads zero.
  piso_shift_reg #(
    .WIDTH (PAT_W)
  ) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (sr_load),
    .shift (sr_shift),
    .din   (sr_din),
    .msb   (ser_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pat_q       <= '0;
      rep_q       <= '0;
      bit_q       <= '0;
      ser_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      rep_q       <= rep_d;
      bit_q       <= bit_d;
      ser_valid_q <= ser_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Output registers are loaded with the value they must show in the state
  // being entered, so every output is a flop.
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    rep_d       = rep_q;
    bit_d       = bit_q;
    ser_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    sr_din      = '0;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          state_d     = SHIFT;
          pat_d       = pattern;
          rep_d       = repeat_cnt;
          bit_d       = BitMax;
          sr_load     = 1'b1;
          sr_din      = pattern;
          ser_valid_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
          rep_d   = '0;
          bit_d   = '0;
          sr_load = 1'b1;
        end else if (bit_q != '0) begin
          bit_d       = bit_q - IdxW'(1);
          sr_shift    = 1'b1;
          ser_valid_d = 1'b1;
          busy_d      = 1'b1;
        end else if (rep_q != '0) begin
          rep_d = rep_q - CNT_W'(1);
`ifdef SERIAL_PATTERN_TX_GAP_EN
          state_d  = GAP;
          sr_shift = 1'b1;
          busy_d   = 1'b1;
`else
          bit_d       = BitMax;
          sr_load     = 1'b1;
          sr_din      = pat_q;
          ser_valid_d = 1'b1;
          busy_d      = 1'b1;
`endif
        end else begin
          state_d  = DONE;
          sr_shift = 1'b1;
          done_d   = 1'b1;
        end
      end
`ifdef SERIAL_PATTERN_TX_GAP_EN
      GAP: begin
        if (abort) begin
          state_d = IDLE;
          rep_d   = '0;
          bit_d   = '0;
          sr_load = 1'b1;
        end else begin
          state_d     = SHIFT;
          bit_d       = BitMax;
          sr_load     = 1'b1;
          sr_din      = pat_q;
          ser_valid_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign load_ready = (state_q == IDLE);
  assign ser_valid  = ser_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
